// File: rtl/up_down_counter_pkg.sv
// Shared limit-mode and prefix-speed constants for the up/down counter slice.
package up_down_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } limit_mode_e;

    localparam int SPEED_SLOW   = 0;
    localparam int SPEED_MEDIUM = 1;
    localparam int SPEED_FAST   = 2;

endpackage

// File: rtl/up_down_counter_incdec.sv
// Incrementer-decrementer: Z = A +/- CI with carry/borrow-out CO, selectable prefix tree.
// Latency: purely combinational; no backpressure.
module IncDecC
    import up_down_counter_pkg::*;
#(
    parameter int width = 8,
    parameter int speed = SPEED_MEDIUM
) (
    input  logic [width-1:0] A,
    input  logic             CI,
    input  logic             DEC,
    output logic [width-1:0] Z,
    output logic             CO
);

    // Bit i toggles when every lower bit "propagates": all ones going up,
    // all zeros going down. That is a prefix AND over A ^ DEC.
    function automatic logic [width-1:0] prefix_and(input logic [width-1:0] p);
        logic [width-1:0] t;
        t = p;
        if (speed == SPEED_FAST) begin
            for (int l = 0; (1 << l) < width; l++) begin
                for (int i = 0; i < width; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        t[i] = t[i] & t[((i >> l) << l) - 1];
                    end
                end
            end
        end else if (speed == SPEED_MEDIUM) begin
            for (int l = 0; (1 << l) < width; l++) begin
                for (int i = (2 << l) - 1; i < width; i += (2 << l)) begin
                    t[i] = t[i] & t[i - (1 << l)];
                end
            end
            for (int l = $clog2(width) - 1; l >= 0; l--) begin
                for (int i = (2 << l) + (1 << l) - 1; i < width; i += (2 << l)) begin
                    t[i] = t[i] & t[i - (1 << l)];
                end
            end
        end else begin
            for (int i = 1; i < width; i++) begin
                t[i] = t[i] & t[i-1];
            end
        end
        return t;
    endfunction

    logic [width-1:0] prop;
    logic [width-1:0] pre;

    assign prop = A ^ {width{DEC}};
    assign pre  = prefix_and(prop);

    assign Z[0] = A[0] ^ CI;
    for (genvar i = 1; i < width; i++) begin : g_sum
        assign Z[i] = A[i] ^ (CI & pre[i-1]);
    end
    assign CO = CI & pre[width-1];

endmodule

// File: rtl/up_down_counter.sv
// Loadable up/down counter with wrap or saturate at the limits and one-cycle ovf/unf pulses.
// Latency: one cycle from request to q_o and flags; no backpressure, every cycle accepted.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int width    = 8,
    parameter int speed    = SPEED_MEDIUM,
    parameter int saturate = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [width-1:0] d_i,
    input  logic             en_i,
    input  logic             dec_i,
    output logic [width-1:0] q_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam limit_mode_e MODE = (saturate != 0) ? SATURATE : WRAP;

    logic [width-1:0] count;
    logic [width-1:0] step_val;
    logic             carry;
    logic             ovf_q;
    logic             unf_q;

    // CI is en_i, so carry can only fire on an enabled step.
    IncDecC #(
        .width (width),
        .speed (speed)
    ) u_incdec (
        .A   (count),
        .CI  (en_i),
        .DEC (dec_i),
        .Z   (step_val),
        .CO  (carry)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            if (clear_i) begin
                count <= '0;
            end else if (load_i) begin
                count <= d_i;
            end else if (en_i) begin
                if (!(carry && MODE == SATURATE)) begin
                    count <= step_val;
                end
                ovf_q <= carry & ~dec_i;
                unf_q <= carry & dec_i;
            end
        end
    end

    assign q_o    = count;
    assign zero_o = (count == '0);
    assign ovf_o  = ovf_q;
    assign unf_o  = unf_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboarded bench: nine counters (width 8 and 5, every speed, wrap and saturate) on shared stimulus.
module tb_up_down_counter;

    localparam int NI = 9;

    typedef struct packed {
        logic [NI-1:0][7:0] q;
        logic [NI-1:0]      ovf;
        logic [NI-1:0]      unf;
        logic [NI-1:0]      zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       en_in = 1'b0;
    logic       dec = 1'b0;

    logic [NI-1:0][7:0] q_w;
    logic [NI-1:0]      ovf_w;
    logic [NI-1:0]      unf_w;
    logic [NI-1:0]      zero_w;

    exp_t sb[$];
    int   mq [NI];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W   = (g < 6) ? 8 : 5;
        localparam int SP  = g % 3;
        localparam int SAT = (g < 6) ? (g / 3) : (g % 2);
        logic [W-1:0] q;
        up_down_counter #(.width(W), .speed(SP), .saturate(SAT)) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .clear_i (clear),
            .load_i  (load),
            .d_i     (d_in[W-1:0]),
            .en_i    (en_in),
            .dec_i   (dec),
            .q_o     (q),
            .zero_o  (zero_w[g]),
            .ovf_o   (ovf_w[g]),
            .unf_o   (unf_w[g])
        );
        assign q_w[g] = 8'(q);
    end

    // Drive one cycle of stimulus, advance the reference model, queue the expectation.
    task automatic step(input logic rst, input logic clr, input logic ld,
                        input logic [7:0] d, input logic en, input logic dc);
        exp_t e;
        rst_n = rst; clear = clr; load = ld; d_in = d; en_in = en; dec = dc;
        for (int i = 0; i < NI; i++) begin
            int w;
            int mx;
            bit s;
            bit ov;
            bit un;
            w  = (i < 6) ? 8 : 5;
            mx = (1 << w) - 1;
            s  = (i < 6) ? (i / 3 != 0) : (i % 2 != 0);
            ov = 1'b0;
            un = 1'b0;
            if (!rst || clr) begin
                mq[i] = 0;
            end else if (ld) begin
                mq[i] = int'(d) & mx;
            end else if (en && !dc) begin
                if (mq[i] == mx) begin
                    ov = 1'b1;
                    if (!s) mq[i] = 0;
                end else begin
                    mq[i] = mq[i] + 1;
                end
            end else if (en && dc) begin
                if (mq[i] == 0) begin
                    un = 1'b1;
                    if (!s) mq[i] = mx;
                end else begin
                    mq[i] = mq[i] - 1;
                end
            end
            e.q[i]    = 8'(mq[i]);
            e.ovf[i]  = ov;
            e.unf[i]  = un;
            e.zero[i] = (mq[i] == 0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, k[0], 8'hA5, 1'b1, k[1]);
            e = sb.pop_front();
            checks++;
            if (q_w !== e.q) begin
                errors++; $display("FAIL reset q got %h want %h", q_w, e.q);
            end
            checks++;
            if ({ovf_w, unf_w, zero_w} !== {e.ovf, e.unf, e.zero}) begin
                errors++; $display("FAIL reset flags got %h want %h", {ovf_w, unf_w, zero_w}, {e.ovf, e.unf, e.zero});
            end
        end
    endtask

    task automatic test_wrap_up();
        exp_t e;
        for (int k = 1; k <= 256; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (q_w !== e.q) begin
                errors++; $display("FAIL wrap_up q step %0d got %h want %h", k, q_w, e.q);
            end
            checks++;
            if ({ovf_w, unf_w, zero_w} !== {e.ovf, e.unf, e.zero}) begin
                errors++; $display("FAIL wrap_up flags step %0d got %h want %h", k, {ovf_w, unf_w, zero_w}, {e.ovf, e.unf, e.zero});
            end
            checks++;
            if (q_w[0] !== 8'(k) || ovf_w[0] !== (k == 256)) begin
                errors++; $display("FAIL wrap_up inst0 step %0d got q=%h ovf=%b want q=%h ovf=%b", k, q_w[0], ovf_w[0], 8'(k), (k == 256));
            end
        end
    endtask

    task automatic test_sat_up();
        exp_t e;
        step(1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (q_w !== e.q) begin
                errors++; $display("FAIL sat_up q step %0d got %h want %h", k, q_w, e.q);
            end
            checks++;
            if ({ovf_w, unf_w, zero_w} !== {e.ovf, e.unf, e.zero}) begin
                errors++; $display("FAIL sat_up flags step %0d got %h want %h", k, {ovf_w, unf_w, zero_w}, {e.ovf, e.unf, e.zero});
            end
            checks++;
            if (q_w[3] !== 8'hFF || ovf_w[3] !== (k >= 2)) begin
                errors++; $display("FAIL sat_up inst3 step %0d got q=%h ovf=%b want q=ff ovf=%b", k, q_w[3], ovf_w[3], (k >= 2));
            end
        end
    endtask

    task automatic test_underflow();
        exp_t e;
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, (k == 0), 1'b1);
            e = sb.pop_front();
            checks++;
            if (q_w !== e.q) begin
                errors++; $display("FAIL underflow q cyc %0d got %h want %h", k, q_w, e.q);
            end
            checks++;
            if ({ovf_w, unf_w, zero_w} !== {e.ovf, e.unf, e.zero}) begin
                errors++; $display("FAIL underflow flags cyc %0d got %h want %h", k, {ovf_w, unf_w, zero_w}, {e.ovf, e.unf, e.zero});
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        logic [2:0] seq_clr;
        logic [2:0] seq_ld;
        logic [2:0] seq_en;
        logic [7:0] seq_d [3];
        seq_clr = 3'b010; seq_ld = 3'b111; seq_en = 3'b010;
        seq_d[0] = 8'hFF; seq_d[1] = 8'h5A; seq_d[2] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, seq_clr[k], seq_ld[k], seq_d[k], seq_en[k], 1'b0);
            e = sb.pop_front();
            checks++;
            if (q_w !== e.q) begin
                errors++; $display("FAIL priority q cyc %0d got %h want %h", k, q_w, e.q);
            end
            checks++;
            if ({ovf_w, unf_w, zero_w} !== {e.ovf, e.unf, e.zero}) begin
                errors++; $display("FAIL priority flags cyc %0d got %h want %h", k, {ovf_w, unf_w, zero_w}, {e.ovf, e.unf, e.zero});
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < 57; k++) begin
            step((k != 55), 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (q_w !== e.q) begin
                errors++; $display("FAIL reset_mid q cyc %0d got %h want %h", k, q_w, e.q);
            end
            checks++;
            if ({ovf_w, unf_w, zero_w} !== {e.ovf, e.unf, e.zero}) begin
                errors++; $display("FAIL reset_mid flags cyc %0d got %h want %h", k, {ovf_w, unf_w, zero_w}, {e.ovf, e.unf, e.zero});
            end
        end
        checks++;
        if (q_w[0] !== 8'h01) begin
            errors++; $display("FAIL reset_mid release got %h want 01", q_w[0]);
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0), 8'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
            e = sb.pop_front();
            checks++;
            if (q_w !== e.q) begin
                errors++; $display("FAIL random q cyc %0d got %h want %h", k, q_w, e.q);
            end
            checks++;
            if ({ovf_w, unf_w, zero_w} !== {e.ovf, e.unf, e.zero}) begin
                errors++; $display("FAIL random flags cyc %0d got %h want %h", k, {ovf_w, unf_w, zero_w}, {e.ovf, e.unf, e.zero});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) mq[i] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap_up();
        test_sat_up();
        test_underflow();
        test_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning counter word width (>= 2).
REQ-002 The block SHALL have parameter speed, default 1, meaning prefix-structure selector passed unchanged to the incrementer-decrementer (0 serial, 1 Brent-Kung, 2 Sklansky).
REQ-003 The block SHALL have parameter saturate, default 0, meaning 0 = wrap on overflow/underflow, 1 = hold at limit.
REQ-004 The block SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port clear_i  input  1  synchronous clear of count to 0.
REQ-007 The block SHALL have port load_i  input  1  synchronous load of d_i.
REQ-008 The block SHALL have port d_i  input  width  load value.
REQ-009 The block SHALL have port en_i  input  1  count enable, step of 1.
REQ-010 The block SHALL have port dec_i  input  1  direction, 1 = down, 0 = up.
REQ-011 The block SHALL have port q_o  output  width  current count (registered).
REQ-012 The block SHALL have port zero_o  output  1  q_o == 0 (combinational from register).
REQ-013 The block SHALL have port ovf_o  output  1  one-cycle pulse, up-count attempted from all-ones.
REQ-014 The block SHALL have port unf_o  output  1  one-cycle pulse, down-count attempted from 0.

Function
REQ-015 Per cycle priority SHALL be: reset > clear_i > load_i > en_i > hold.
REQ-016 With en_i=1 and no higher-priority request, next count SHALL be q_o+1 (dec_i=0) or q_o-1 (dec_i=1), modulo 2^width.
REQ-017 Carry/borrow SHALL be the incrementer-decrementer carry-out with CI=en_i, DEC=dec_i; no separate comparator for limit detection.
REQ-018 On carry-out with saturate=0 the count SHALL wrap (all-ones->0 up, 0->all-ones down).
REQ-019 On carry-out with saturate=1 the count SHALL hold its current value.
REQ-020 ovf_o/unf_o SHALL be registered, asserted in the cycle after the limit-crossing step, for exactly one cycle, in both saturate modes.
REQ-021 clear_i or load_i in the same cycle as a limit-crossing en_i SHALL suppress ovf_o/unf_o.
REQ-022 Consecutive enabled steps at a saturated limit SHALL pulse ovf_o/unf_o every cycle.
REQ-023 Latency: q_o SHALL reflect clear/load/step one cycle after the request edge; en_i=0 SHALL hold q_o indefinitely.
REQ-024 zero_o SHALL equal (q_o == 0) in every cycle including reset.

Reset
REQ-025 With rst_ni=0 at a rising edge, q_o SHALL become 0, ovf_o 0, unf_o 0, regardless of other inputs.
REQ-026 Reset asserted mid-count SHALL discard the pending step; first step after release SHALL start from 0.
REQ-027 No output SHALL be X after the first reset edge; no asynchronous reset path SHALL exist.

Structure
REQ-028 Next-value arithmetic SHALL be one instance of the existing incrementer-decrementer (IncDecC), width and speed forwarded.
REQ-029 A shared package SHALL hold a typedef enum for the limit mode (WRAP=0, SATURATE=1) and the prefix speed constants (SPEED_SLOW=0, SPEED_MEDIUM=1, SPEED_FAST=2).
REQ-030 State SHALL be limited to the count register and the two pulse flops; no other sub-modules.

Verification
REQ-031 width=8, saturate=0: reset, en_i=1 dec_i=0 for 256 cycles -> q_o 0..255 then 0; ovf_o one pulse the cycle q_o returns to 0.
REQ-032 width=8, saturate=1: load 0xFE, count up 3 cycles -> q_o 0xFF,0xFF,0xFF; ovf_o pulses on cycles 2 and 3 only.
REQ-033 width=8, saturate=0: q_o=0, en_i=1 dec_i=1 -> q_o=0xFF, unf_o=1 one cycle, zero_o falls.
REQ-034 clear_i, load_i (d_i=0x5A) and en_i in one cycle with q_o=0xFF -> q_o=0, no ovf_o; next cycle load only -> q_o=0x5A.
REQ-035 Count to 0x37, drop rst_ni one cycle with en_i=1 -> q_o=0, flags 0; release -> 0x01 next cycle.
REQ-036 Repeat REQ-031..035 for speed=0,1,2 and width=5 against a behavioural reference model; results SHALL match cycle-exactly.
